// File: rtl/poci_master_pkg.sv
// Shared POCI definitions: FSM state encoding, bus data width and the
// peripheral address map used by the leds/keys slaves.
package pk_poci;

    typedef enum logic [1:0] {
        POCI_IDLE   = 2'd0,
        POCI_SETUP  = 2'd1,
        POCI_ACCESS = 2'd2,
        POCI_RESP   = 2'd3
    } poci_state_t;

    localparam int POCI_DATA_WIDTH = 32;

    localparam logic [31:0] POCI_LEDS_BASE = 32'h0000_0000;
    localparam logic [31:0] POCI_KEYS_BASE = 32'h0000_0010;

endpackage

// File: rtl/poci_master.sv
// POCI initiator: one valid/ready request becomes one SETUP+ACCESS transfer,
// and the result comes back on a held valid/ready response channel.
module poci_master
    import pk_poci::*;
#(
    parameter int PADDR_WIDTH = 32,
    parameter int TIMEOUT     = 1023
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [PADDR_WIDTH-1:0]     req_addr,
    input  logic [POCI_DATA_WIDTH-1:0] req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [POCI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_timeout,
    output logic [PADDR_WIDTH-1:0]     paddr,
    output logic                       pwrite,
    output logic                       psel,
    output logic                       penable,
    output logic [POCI_DATA_WIDTH-1:0] pwdata,
    input  logic [POCI_DATA_WIDTH-1:0] prdata,
    input  logic                       pready,
    input  logic                       pslverr,
    output logic [1:0]                 dbg_state
);

    // Handshake rule for both channels: a beat transfers on the pclk edge where
    // valid and ready are both 1; the source holds its payload until then.

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    poci_state_t                state, nxt_state;
    logic [CW-1:0]              cnt, nxt_cnt;
    logic                       nxt_req_ready, nxt_rsp_valid, nxt_rsp_err, nxt_rsp_timeout;
    logic [POCI_DATA_WIDTH-1:0] nxt_rsp_rdata, nxt_pwdata;
    logic [PADDR_WIDTH-1:0]     nxt_paddr;
    logic                       nxt_pwrite, nxt_psel, nxt_penable;

    assign dbg_state = state;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state       <= POCI_IDLE;
            cnt         <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            req_ready   <= nxt_req_ready;
            rsp_valid   <= nxt_rsp_valid;
            rsp_rdata   <= nxt_rsp_rdata;
            rsp_err     <= nxt_rsp_err;
            rsp_timeout <= nxt_rsp_timeout;
            paddr       <= nxt_paddr;
            pwrite      <= nxt_pwrite;
            pwdata      <= nxt_pwdata;
            psel        <= nxt_psel;
            penable     <= nxt_penable;
        end
    end

    always_comb begin
        nxt_state       = state;
        nxt_cnt         = cnt;
        nxt_req_ready   = req_ready;
        nxt_rsp_valid   = rsp_valid;
        nxt_rsp_rdata   = rsp_rdata;
        nxt_rsp_err     = rsp_err;
        nxt_rsp_timeout = rsp_timeout;
        nxt_paddr       = paddr;
        nxt_pwrite      = pwrite;
        nxt_pwdata      = pwdata;
        nxt_psel        = psel;
        nxt_penable     = penable;

        case (state)
            POCI_IDLE: begin
                if (req_valid) begin
                    nxt_paddr     = req_addr;
                    nxt_pwrite    = req_write;
                    nxt_pwdata    = req_wdata;
                    nxt_psel      = 1'b1;
                    nxt_req_ready = 1'b0;
                    nxt_state     = POCI_SETUP;
                end
            end
            POCI_SETUP: begin
                nxt_penable = 1'b1;
                nxt_cnt     = '0;
                nxt_state   = POCI_ACCESS;
            end
            POCI_ACCESS: begin
                // pready is tested first so a completion beats a same-edge timeout.
                if (pready) begin
                    nxt_rsp_rdata   = pwrite ? '0 : prdata;
                    nxt_rsp_err     = pslverr;
                    nxt_rsp_timeout = 1'b0;
                    nxt_rsp_valid   = 1'b1;
                    nxt_psel        = 1'b0;
                    nxt_penable     = 1'b0;
                    nxt_state       = POCI_RESP;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    nxt_rsp_rdata   = '0;
                    nxt_rsp_err     = 1'b0;
                    nxt_rsp_timeout = 1'b1;
                    nxt_rsp_valid   = 1'b1;
                    nxt_psel        = 1'b0;
                    nxt_penable     = 1'b0;
                    nxt_state       = POCI_RESP;
                end else if (TIMEOUT != 0) begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            POCI_RESP: begin
                if (rsp_ready) begin
                    nxt_rsp_valid = 1'b0;
                    nxt_req_ready = 1'b1;
                    nxt_state     = POCI_IDLE;
                end
            end
            default: nxt_state = POCI_IDLE;
        endcase
    end

endmodule

// File: tb/tb_poci_master.sv
// Bench for poci_master (TIMEOUT=8): table of transfers driven through a slave
// model, responses checked against a scoreboard queue, plus a mid-ACCESS reset.
module tb_poci_master;
    import pk_poci::*;

    localparam int TO = 8;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata;
    logic        pwrite, psel, penable;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;
    logic [1:0]  dbg_state;

    always #5 pclk = ~pclk;

    poci_master #(.PADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          waits;     // ACCESS cycles with pready=0 before pready=1
        int          bp;        // cycles rsp_ready is held low
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_cyc;   // ACCESS cycles expected on the bus
    } vec_t;

    vec_t        vecs[8];
    logic [33:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic se, input int w, input int b,
                                input logic [31:0] er, input logic ee, input logic et, input int ec);
        vec_t v;
        v.write = wr; v.addr = a; v.wdata = wd; v.prdata = rd; v.slverr = se;
        v.waits = w; v.bp = b; v.exp_rdata = er; v.exp_err = ee; v.exp_to = et; v.exp_cyc = ec;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int          cyc;
        int          acc;
        logic        stable;
        logic [33:0] exp;
        logic [33:0] got;
        @(negedge pclk);
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        pready = 1'b0; prdata = v.prdata; pslverr = v.slverr;
        exp_q.push_back({v.exp_to, v.exp_err, v.exp_rdata});
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge pclk);
            cyc++;
        end
        check({tag, "_req_ready"}, req_ready, 1);
        @(negedge pclk);
        req_valid = 1'b0; req_addr = '1; req_wdata = '1; req_write = ~v.write;
        check({tag, "_setup_psel_penable"}, {psel, penable}, 2'b10);
        check({tag, "_setup_paddr"}, paddr, v.addr);
        check({tag, "_setup_state"}, dbg_state, POCI_SETUP);
        check({tag, "_setup_rsp_valid"}, rsp_valid, 0);
        @(negedge pclk);
        acc = 0;
        stable = 1'b1;
        while (psel && acc < 40) begin
            if (!penable || paddr !== v.addr || pwrite !== v.write || pwdata !== v.wdata || rsp_valid)
                stable = 1'b0;
            pready = (acc == v.waits);
            acc++;
            @(negedge pclk);
        end
        pready = 1'b0;
        check({tag, "_access_cycles"}, acc, v.exp_cyc);
        check({tag, "_access_stable"}, stable, 1);
        check({tag, "_penable_drop"}, penable, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        got = {rsp_timeout, rsp_err, rsp_rdata};
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_scoreboard: response 0x%0h with nothing expected", tag, got);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_rsp_fields"}, got, exp);
        end
        for (int i = 0; i < v.bp; i++) begin
            req_valid = 1'b1;
            @(negedge pclk);
            check({tag, "_bp_hold"}, {rsp_valid, rsp_timeout, rsp_err, rsp_rdata}, {1'b1, got});
            check({tag, "_bp_req_psel"}, {req_ready, psel}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check({tag, "_post_hs"}, {rsp_valid, req_ready}, 2'b01);
        @(negedge pclk);
        check({tag, "_post_hs_psel"}, psel, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0, r1, r2;
        int          cyc;
        r0 = $urandom; r1 = $urandom; r2 = $urandom;
        vecs[0] = mk(1'b0, 32'h10, 32'h0,  32'hDEADBEEF, 1'b0, 0,  0, 32'hDEADBEEF, 1'b0, 1'b0, 1);
        vecs[1] = mk(1'b1, 32'h04, 32'hA5, 32'h12345678, 1'b0, 3,  0, 32'h0,        1'b0, 1'b0, 4);
        vecs[2] = mk(1'b0, 32'h08, 32'h0,  32'hCAFE0001, 1'b1, 1,  0, 32'hCAFE0001, 1'b1, 1'b0, 2);
        vecs[3] = mk(1'b0, 32'h0C, 32'h0,  32'hFFFFFFFF, 1'b1, 20, 0, 32'h0,        1'b0, 1'b1, TO);
        vecs[4] = mk(1'b0, 32'h0C, 32'h0,  32'h0BADF00D, 1'b0, TO - 1, 0, 32'h0BADF00D, 1'b0, 1'b0, TO);
        vecs[5] = mk(1'b1, 32'h14, r0,     r1,           1'b0, 2,  5, 32'h0,        1'b0, 1'b0, 3);
        vecs[6] = mk(1'b1, 32'h18, 32'h1,  32'h55AA55AA, 1'b1, 0,  0, 32'h0,        1'b1, 1'b0, 1);
        vecs[7] = mk(1'b0, 32'h10, r0,     r2,           1'b0, 2,  3, r2,           1'b0, 1'b0, 3);

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check("reset_bus", {psel, penable, pwrite}, 3'b000);
        check("reset_paddr", paddr, 0);
        check("reset_pwdata", pwdata, 0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
        check("reset_req_ready", req_ready, 1);
        check("reset_state", dbg_state, POCI_IDLE);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset during ACCESS wait states: transfer vanishes, no response.
        @(negedge pclk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1C; prdata = 32'h11111111; pready = 1'b0;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge pclk);
            cyc++;
        end
        @(negedge pclk);
        req_valid = 1'b0;
        repeat (2) @(negedge pclk);
        check("rst_pre_access", {psel, penable, dbg_state}, {2'b11, POCI_ACCESS});
        presetn = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        check("rst_bus_dropped", {psel, penable, rsp_valid}, 3'b000);
        check("rst_req_ready", req_ready, 1);
        check("rst_paddr", paddr, 0);
        pready = 1'b1;
        repeat (3) begin
            @(negedge pclk);
            check("rst_no_rsp", {rsp_valid, psel}, 2'b00);
        end
        pready = 1'b0;
        run_vec(vecs[0], "after_rst");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
